vpe_bias_sched: RTL and testbench

Bias scheduler for the VPE bias adder stage. Holds a small bias table, accepts a stream of 1x8 int8 activation vectors from upstream with a valid/ready handshake, and issues each vector to the bias adder in one registered beat. Each beat carries the matching bias vector, the ReLU enable, and the destination register-file index and mux select. It counts adder completions and signals layer done after the last result has left the adder.

---
 rtl/vpe_bias_sched.sv | 187 ++++++++++++++++++
 tb/tb_vpe_bias_sched.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vpe_bias_sched.sv
// Bias scheduler for the VPE bias adder: holds the bias table, pairs each accepted
// activation vector with its bias entry and issues it to the adder in one registered beat.
//
//  state | meaning
//  IDLE  | waiting for a start; bias table writable
//  RUN   | accepting activations, one beat issued per accept
//  DRAIN | all vectors issued, waiting for the adder completions
module vpe_bias_sched #(
    parameter int BIAS_DEPTH = 16,
    parameter int PTR_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_bias_wr_en,
    input  logic [PTR_W-1:0] i_bias_wr_addr,
    input  logic [63:0]      i_bias_wr_data,
    input  logic             i_cfg_start,
    input  logic [PTR_W-1:0] i_cfg_bias_base,
    input  logic [PTR_W:0]   i_cfg_bias_len,
    input  logic [15:0]      i_cfg_vec_cnt,
    input  logic             i_cfg_en_relu,
    input  logic [4:0]       i_cfg_rf_idx,
    input  logic [1:0]       i_cfg_rf_mux,
    input  logic [63:0]      i_act_data,
    input  logic             i_act_v,
    output logic             o_act_rdy,
    output logic [63:0]      o_add_data,
    output logic             o_add_data_v,
    output logic [63:0]      o_add_bias,
    output logic             o_add_en_relu,
    output logic [4:0]       o_add_rf_idx,
    output logic [1:0]       o_add_rf_mux,
    input  logic             i_add_res_v,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [PTR_W:0] LEN_MAX = (PTR_W+1)'(BIAS_DEPTH);
    localparam logic [PTR_W:0] LEN_ONE = (PTR_W+1)'(1);

    state_t state_q, state_d;

    logic [63:0]      tbl_q [BIAS_DEPTH];
    logic [PTR_W-1:0] base_q;
    logic [PTR_W:0]   len_q;
    logic [15:0]      vec_cnt_q;
    logic             relu_q;
    logic [1:0]       mux_q;
    logic [PTR_W-1:0] offset_q, offset_d;
    logic [4:0]       rf_q;
    logic [15:0]      issue_q;
    logic [15:0]      done_cnt_q, done_cnt_d;

    logic [63:0]      add_data_q;
    logic [63:0]      add_bias_q;
    logic             add_v_q;
    logic             add_relu_q;
    logic [4:0]       add_rf_q;
    logic [1:0]       add_mux_q;
    logic             done_q;
    logic             err_q;

    logic             idle;
    logic             cfg_ok;
    logic             go;
    logic             accept;
    logic             issue_last;
    logic             tbl_we;
    logic [PTR_W-1:0] bias_addr;
    logic [PTR_W:0]   offset_inc;

    assign idle       = (state_q == ST_IDLE);
    assign cfg_ok     = (i_cfg_vec_cnt != 16'd0) && (i_cfg_bias_len != '0) &&
                        (i_cfg_bias_len <= LEN_MAX);
    assign go         = idle && i_cfg_start && cfg_ok;
    assign accept     = (state_q == ST_RUN) && i_act_v;
    assign issue_last = ((issue_q + 16'd1) == vec_cnt_q);
    assign tbl_we     = idle && i_bias_wr_en;
    // Address truncates to PTR_W bits so a period may wrap past the table end.
    assign bias_addr  = base_q + offset_q;
    assign offset_inc = {1'b0, offset_q} + LEN_ONE;
    assign offset_d   = (offset_inc == len_q) ? '0 : offset_inc[PTR_W-1:0];

    always_comb begin
        done_cnt_d = done_cnt_q;
        if (go) begin
            done_cnt_d = '0;
        end else if (!idle && i_add_res_v && (done_cnt_q != vec_cnt_q)) begin
            done_cnt_d = done_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (go) state_d = ST_RUN;
            ST_RUN:   if (accept && issue_last) state_d = ST_DRAIN;
            ST_DRAIN: if (done_cnt_d == vec_cnt_q) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_act_rdy = (state_q == ST_RUN);
        o_busy    = !idle;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BIAS_DEPTH; i++) tbl_q[i] <= '0;
        end else if (tbl_we) begin
            tbl_q[i_bias_wr_addr] <= i_bias_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q     <= '0;
            len_q      <= '0;
            vec_cnt_q  <= '0;
            relu_q     <= 1'b0;
            mux_q      <= '0;
            offset_q   <= '0;
            rf_q       <= '0;
            issue_q    <= '0;
            done_cnt_q <= '0;
            add_data_q <= '0;
            add_bias_q <= '0;
            add_v_q    <= 1'b0;
            add_relu_q <= 1'b0;
            add_rf_q   <= '0;
            add_mux_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_cnt_q <= done_cnt_d;
            add_v_q    <= accept;
            err_q      <= idle && i_cfg_start && !cfg_ok;
            done_q     <= (state_q == ST_DRAIN) && (done_cnt_d == vec_cnt_q);
            if (go) begin
                base_q    <= i_cfg_bias_base;
                len_q     <= i_cfg_bias_len;
                vec_cnt_q <= i_cfg_vec_cnt;
                relu_q    <= i_cfg_en_relu;
                mux_q     <= i_cfg_rf_mux;
                offset_q  <= '0;
                rf_q      <= i_cfg_rf_idx;
                issue_q   <= '0;
            end
            if (accept) begin
                add_data_q <= i_act_data;
                add_bias_q <= tbl_q[bias_addr];
                add_relu_q <= relu_q;
                add_rf_q   <= rf_q;
                add_mux_q  <= mux_q;
                offset_q   <= offset_d;
                rf_q       <= rf_q + 5'd1;
                issue_q    <= issue_q + 16'd1;
            end
        end
    end

    assign o_add_data    = add_data_q;
    assign o_add_data_v  = add_v_q;
    assign o_add_bias    = add_bias_q;
    assign o_add_en_relu = add_relu_q;
    assign o_add_rf_idx  = add_rf_q;
    assign o_add_rf_mux  = add_mux_q;
    assign o_done        = done_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_vpe_bias_sched.sv
// Directed bench for vpe_bias_sched: a reference model queues the expected adder beats
// at each accept, and a negedge monitor pops and compares them and plays the adder.
module tb_vpe_bias_sched;
    localparam int DEPTH = 16;
    localparam int PTR_W = 4;

    typedef struct packed {
        logic [63:0] data;
        logic [63:0] bias;
        logic        relu;
        logic [4:0]  rf;
        logic [1:0]  mux;
    } beat_t;

    logic             clk;
    logic             rst_n;
    logic             i_bias_wr_en;
    logic [PTR_W-1:0] i_bias_wr_addr;
    logic [63:0]      i_bias_wr_data;
    logic             i_cfg_start;
    logic [PTR_W-1:0] i_cfg_bias_base;
    logic [PTR_W:0]   i_cfg_bias_len;
    logic [15:0]      i_cfg_vec_cnt;
    logic             i_cfg_en_relu;
    logic [4:0]       i_cfg_rf_idx;
    logic [1:0]       i_cfg_rf_mux;
    logic [63:0]      i_act_data;
    logic             i_act_v;
    logic             o_act_rdy;
    logic [63:0]      o_add_data;
    logic             o_add_data_v;
    logic [63:0]      o_add_bias;
    logic             o_add_en_relu;
    logic [4:0]       o_add_rf_idx;
    logic [1:0]       o_add_rf_mux;
    logic             i_add_res_v = 1'b0;
    logic             o_busy;
    logic             o_done;
    logic             o_err;

    vpe_bias_sched #(.BIAS_DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_bias_wr_en(i_bias_wr_en), .i_bias_wr_addr(i_bias_wr_addr),
        .i_bias_wr_data(i_bias_wr_data),
        .i_cfg_start(i_cfg_start), .i_cfg_bias_base(i_cfg_bias_base),
        .i_cfg_bias_len(i_cfg_bias_len), .i_cfg_vec_cnt(i_cfg_vec_cnt),
        .i_cfg_en_relu(i_cfg_en_relu), .i_cfg_rf_idx(i_cfg_rf_idx),
        .i_cfg_rf_mux(i_cfg_rf_mux),
        .i_act_data(i_act_data), .i_act_v(i_act_v), .o_act_rdy(o_act_rdy),
        .o_add_data(o_add_data), .o_add_data_v(o_add_data_v), .o_add_bias(o_add_bias),
        .o_add_en_relu(o_add_en_relu), .o_add_rf_idx(o_add_rf_idx),
        .o_add_rf_mux(o_add_rf_mux), .i_add_res_v(i_add_res_v),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    beat_t       sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_seen = 0;
    int          done_cyc = 0;
    int          last_acc_cyc = 0;
    logic        pend = 1'b0;

    logic [63:0] m_tbl [DEPTH];
    int          m_base, m_len, m_cnt, m_iss, m_off, m_rf;
    logic        m_relu;
    logic [1:0]  m_mux;
    bit          m_run = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor and adder model: a result pulse follows each issued beat by one cycle.
    initial forever begin
        beat_t e;
        @(negedge clk);
        i_add_res_v = pend;
        pend = o_add_data_v;
        if (o_add_data_v === 1'b1) begin
            if (sb.size() == 0) begin
                check("v_without_accept", o_add_data_v, 1'b0);
            end else begin
                e = sb.pop_front();
                check("beat", {o_add_data, o_add_bias, o_add_en_relu, o_add_rf_idx, o_add_rf_mux}, e);
            end
        end
        if (o_done === 1'b1) begin
            done_seen++;
            done_cyc = cyc;
            check("busy_at_done", o_busy, 1'b0);
        end
    end

    task automatic wr_bias(input int addr, input logic [63:0] data);
        i_bias_wr_en   = 1'b1;
        i_bias_wr_addr = PTR_W'(addr);
        i_bias_wr_data = data;
        tick();
        i_bias_wr_en   = 1'b0;
        m_tbl[addr] = data;
    endtask

    task automatic start(input int base, input int len, input int cnt, input logic relu,
                         input int rf, input logic [1:0] mux, input bit bad);
        i_cfg_bias_base = PTR_W'(base);
        i_cfg_bias_len  = (PTR_W+1)'(len);
        i_cfg_vec_cnt   = 16'(cnt);
        i_cfg_en_relu   = relu;
        i_cfg_rf_idx    = 5'(rf);
        i_cfg_rf_mux    = mux;
        i_cfg_start     = 1'b1;
        tick();
        i_cfg_start     = 1'b0;
        check("err_after_start", o_err, bad);
        check("busy_after_start", o_busy, !bad);
        if (!bad) begin
            m_base = base; m_len = len; m_cnt = cnt; m_relu = relu;
            m_rf = rf; m_mux = mux; m_off = 0; m_iss = 0; m_run = 1;
        end else begin
            tick();
            check("err_one_cycle", o_err, 1'b0);
            check("busy_after_reject", o_busy, 1'b0);
        end
    endtask

    task automatic act_step(input logic v);
        bit          exp_rdy;
        logic [63:0] d;
        beat_t       e;
        exp_rdy = m_run && (m_iss < m_cnt);
        d = {$urandom, $urandom};
        i_act_v = v;
        i_act_data = d;
        check("act_rdy", o_act_rdy, exp_rdy);
        if (v && exp_rdy) begin
            e.data = d;
            e.bias = m_tbl[(m_base + m_off) % DEPTH];
            e.relu = m_relu;
            e.rf   = 5'(m_rf);
            e.mux  = m_mux;
            sb.push_back(e);
            m_off = (m_off + 1 == m_len) ? 0 : m_off + 1;
            m_rf  = (m_rf + 1) % 32;
            m_iss++;
            last_acc_cyc = cyc;
        end
        tick();
        i_act_v = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int prev;
        bit got;
        prev = done_seen;
        got = 0;
        for (int i = 0; i < budget; i++) begin
            if (done_seen != prev) begin
                got = 1;
                break;
            end
            tick();
        end
        check("done_seen", got, 1'b1);
        if (got) begin
            check("done_latency", done_cyc - last_acc_cyc, 3);
            check("rdy_after_done", o_act_rdy, 1'b0);
        end
        m_run = 0;
        check("sb_empty", sb.size(), 0);
        tick();
        check("single_done", done_seen, prev + 1);
    endtask

    initial begin
        int prev_done;
        i_bias_wr_en = 0; i_bias_wr_addr = '0; i_bias_wr_data = '0;
        i_cfg_start = 0; i_cfg_bias_base = '0; i_cfg_bias_len = '0; i_cfg_vec_cnt = '0;
        i_cfg_en_relu = 0; i_cfg_rf_idx = '0; i_cfg_rf_mux = '0;
        i_act_data = '0; i_act_v = 0;
        for (int k = 0; k < DEPTH; k++) m_tbl[k] = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) tick();
        check("reset_outputs", {o_act_rdy, o_add_data, o_add_data_v, o_add_bias, o_add_en_relu,
              o_add_rf_idx, o_add_rf_mux, o_busy, o_done, o_err}, '0);
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < DEPTH; k++) wr_bias(k, {8{8'(k)}});

        // Period of 4 biases, 6 vectors, continuous valid: two extra cycles must not accept.
        start(0, 4, 6, 1'b1, 3, 2'd0, 0);
        for (int i = 0; i < 8; i++) act_step(1'b1);
        wait_done(20);

        start(14, 4, 4, 1'b0, 0, 2'd2, 0);
        for (int i = 0; i < 4; i++) act_step(1'b1);
        wait_done(20);

        start(0, 16, 4, 1'b1, 30, 2'd1, 0);
        for (int i = 0; i < 4; i++) act_step(1'b1);
        wait_done(20);

        start(0, 4, 0, 1'b0, 0, 2'd0, 1);
        start(0, 0, 4, 1'b0, 0, 2'd0, 1);
        start(0, 17, 4, 1'b0, 0, 2'd0, 1);
        act_step(1'b1);

        // Gapped valid; table write and restart attempt land in the idle slots.
        start(0, 4, 4, 1'b0, 10, 2'd1, 0);
        act_step(1'b1);
        i_bias_wr_en = 1'b1; i_bias_wr_addr = 4'd1; i_bias_wr_data = '1;
        act_step(1'b0);
        i_bias_wr_en = 1'b0;
        act_step(1'b1);
        act_step(1'b1);
        i_cfg_bias_base = 4'd9; i_cfg_vec_cnt = 16'd2; i_cfg_start = 1'b1;
        act_step(1'b0);
        i_cfg_start = 1'b0;
        check("err_in_run", o_err, 1'b0);
        check("busy_in_run", o_busy, 1'b1);
        act_step(1'b1);
        wait_done(20);

        // Reset in the middle of a 5-vector layer.
        start(0, 4, 5, 1'b1, 0, 2'd3, 0);
        act_step(1'b1);
        act_step(1'b1);
        rst_n = 1'b0;
        #1;
        check("outputs_in_reset", {o_act_rdy, o_add_data, o_add_data_v, o_add_bias, o_add_en_relu,
              o_add_rf_idx, o_add_rf_mux, o_busy, o_done, o_err}, '0);
        sb.delete();
        m_run = 0;
        for (int k = 0; k < DEPTH; k++) m_tbl[k] = '0;
        prev_done = done_seen;
        repeat (3) tick();
        check("no_done_in_reset", done_seen, prev_done);
        rst_n = 1'b1;
        repeat (2) tick();
        check("idle_after_reset", o_busy, 1'b0);

        start(0, 4, 3, 1'b1, 7, 2'd3, 0);
        for (int i = 0; i < 3; i++) act_step(1'b1);
        wait_done(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
